// File: rtl/shift_rotate_sched.sv
// Round-robin scheduler sharing one rotate-right barrel unit among Ports requesters.
// Two-stage pipeline: S1 issue register, S2 output register with valid/ready response.
module shift_rotate_sched #(
  parameter int Bits  = 64,
  parameter int Ports = 4,
  parameter int SW    = $clog2(Bits),
  parameter int IW    = $clog2(Ports)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [Ports-1:0]      req_valid,
  output logic [Ports-1:0]      req_ready,
  input  logic [Ports*Bits-1:0] req_a,
  input  logic [Ports*SW-1:0]   req_sh,
  input  logic [Ports-1:0]      req_left,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Bits-1:0]       rsp_b,
  output logic [IW-1:0]         rsp_id,
  output logic [15:0]           ops_done
);

  logic [Ports-1:0][Bits-1:0] pa;
  logic [Ports-1:0][SW-1:0]   ps;
  assign pa = req_a;
  assign ps = req_sh;

  logic [IW-1:0]   ptr;
  logic            v1;
  logic [Bits-1:0] a1;
  logic [IW-1:0]   id1;
  logic [SW-1:0]   eff1;

  // First valid port at or after ptr; MSB flags that any port is valid.
  function automatic logic [IW:0] pick(input logic [Ports-1:0] v, input logic [IW-1:0] p);
    logic [IW:0] r;
    int          j;
    r = '0;
    for (int i = Ports-1; i >= 0; i--) begin
      j = (int'(p) + i) % Ports;
      if (v[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  logic [IW:0]   sel;
  logic          found;
  logic [IW-1:0] gid;
  logic          s2_free, s1_load, gnt;
  logic [SW-1:0] sh_g, eff_n;
  logic [Bits-1:0] rot;

  assign sel     = pick(req_valid, ptr);
  assign found   = sel[IW];
  assign gid     = sel[IW-1:0];
  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_load = !v1 || s2_free;
  assign gnt     = reset_n && found && s1_load;

  for (genvar p = 0; p < Ports; p++) begin : g_rdy
    assign req_ready[p] = gnt && (gid == IW'(p));
  end

  // Left rotate by sh == right rotate by (Bits - sh) mod Bits, i.e. -sh in SW bits.
  assign sh_g  = ps[gid];
  assign eff_n = req_left[gid] ? (~sh_g + SW'(1)) : sh_g;

  // Equivalent to the low half of {a,a} >> eff; eff=0 degenerates to a | a.
  assign rot = (a1 >> eff1) | (a1 << (SW'(0) - eff1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= '0;
      v1        <= 1'b0;
      a1        <= '0;
      id1       <= '0;
      eff1      <= '0;
      rsp_valid <= 1'b0;
      rsp_b     <= '0;
      rsp_id    <= '0;
      ops_done  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
      if (s2_free) begin
        rsp_valid <= v1;
        if (v1) begin
          rsp_b  <= rot;
          rsp_id <= id1;
        end
      end
      if (s1_load) begin
        v1 <= gnt;
        if (gnt) begin
          a1   <= pa[gid];
          id1  <= gid;
          eff1 <= eff_n;
          ptr  <= (gid == IW'(Ports-1)) ? '0 : gid + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rotate_sched.sv
// Directed vector table plus hand-written pipeline sequences and a scoreboarded random soak.
module tb_shift_rotate_sched;
  localparam int Bits = 64, Ports = 4, SW = 6, IW = 2;

  logic                  clk, reset_n, rsp_ready, rsp_valid;
  logic [Ports-1:0]      req_valid, req_ready, req_left;
  logic [Ports*Bits-1:0] req_a;
  logic [Ports*SW-1:0]   req_sh;
  logic [Bits-1:0]       rsp_b;
  logic [IW-1:0]         rsp_id;
  logic [15:0]           ops_done;

  shift_rotate_sched #(.Bits(Bits), .Ports(Ports)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_sh(req_sh), .req_left(req_left), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_b(rsp_b), .rsp_id(rsp_id), .ops_done(ops_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int port; logic [63:0] a; logic [5:0] sh; logic left; logic [63:0] exp; } vec_t;
  typedef struct { logic [IW-1:0] id; logic [63:0] b; } exp_t;

  vec_t tv[8];
  exp_t q[$];
  int   nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rot_ref(input logic [63:0] a, input int sh, input logic left);
    logic [63:0] r;
    r = a;
    for (int i = 0; i < sh; i++) r = left ? {r[62:0], r[63]} : {r[0], r[63:1]};
    return r;
  endfunction

  task automatic set_port(input int p, input logic [63:0] a, input logic [5:0] sh, input logic left);
    req_a[p*Bits +: Bits] = a;
    req_sh[p*SW +: SW]    = sh;
    req_left[p]           = left;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    cyc();
    reset_n = 1'b1;
  endtask

  // One isolated request: accepted immediately, visible two clock edges after it is presented.
  task automatic apply(input vec_t v, input int n);
    set_port(v.port, v.a, v.sh, v.left);
    req_valid = 4'b1 << v.port;
    #1 chk("vec ready", 64'(req_ready), 64'(4'b1 << v.port));
    cyc();
    req_valid = '0;
    chk("vec s1 only", 64'(rsp_valid), 64'd0);
    cyc();
    chk("vec valid", 64'(rsp_valid), 64'd1);
    chk("vec b", rsp_b, v.exp);
    chk("vec id", 64'(rsp_id), 64'(v.port));
    cyc();
    chk("vec ops_done", 64'(ops_done), 64'(n));
    chk("vec drained", 64'(rsp_valid), 64'd0);
  endtask

  logic [63:0] ba[Ports];
  logic [Ports-1:0] pend;
  int scnt;

  initial begin
    tv[0] = '{0, 64'h0123456789ABCDEF, 6'd4,  1'b0, 64'hF0123456789ABCDE};
    tv[1] = '{2, 64'h0123456789ABCDEF, 6'd4,  1'b1, 64'h123456789ABCDEF0};
    tv[2] = '{1, 64'h0123456789ABCDEF, 6'd0,  1'b1, 64'h0123456789ABCDEF};
    tv[3] = '{3, 64'h0123456789ABCDEF, 6'd63, 1'b0, 64'h02468ACF13579BDE};
    tv[4] = '{1, 64'h0123456789ABCDEF, 6'd0,  1'b0, 64'h0123456789ABCDEF};
    tv[5] = '{3, 64'h8000000000000001, 6'd1,  1'b1, 64'h0000000000000003};
    tv[6] = '{0, 64'h0123456789ABCDEF, 6'd32, 1'b0, 64'h89ABCDEF01234567};
    tv[7] = '{2, 64'h0000000000000001, 6'd63, 1'b1, 64'h8000000000000000};
    for (int p = 0; p < Ports; p++) ba[p] = 64'hA5A5_0000_0000_0000 | 64'(p * 17 + 3);

    // Reset state, with every port requesting to show req_ready is forced low.
    req_a = '0; req_sh = '0; req_left = '0; rsp_ready = 1'b1;
    reset_n = 1'b0; req_valid = 4'hF;
    @(posedge clk); cyc();
    #1;
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_b", rsp_b, 64'd0);
    chk("rst rsp_id", 64'(rsp_id), 64'd0);
    chk("rst ops_done", 64'(ops_done), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1; req_valid = '0;

    for (int i = 0; i < 8; i++) apply(tv[i], i + 1);

    // Round robin, all ports valid, full throughput.
    do_reset();
    for (int p = 0; p < Ports; p++) set_port(p, ba[p], 6'd0, 1'b0);
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #1 chk("rr grant", 64'(req_ready), 64'(4'b1 << (i % 4)));
      if (i >= 2) begin
        chk("rr rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr rsp_id", 64'(rsp_id), 64'((i - 2) % 4));
        chk("rr rsp_b", rsp_b, ba[(i - 2) % 4]);
      end
      cyc();
    end
    req_valid = '0; cyc(); cyc();

    // Only ports 1 and 3 valid after reset.
    do_reset();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr13 grant", 64'(req_ready), 64'(4'b1 << ((i % 2) ? 3 : 1)));
      cyc();
    end
    req_valid = '0; cyc(); cyc();

    // Backpressure: fill S1 and S2, hold, then release.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    #1 chk("bp grant0", 64'(req_ready), 64'd1);
    cyc(); req_valid = 4'b0110;
    #1 chk("bp grant1", 64'(req_ready), 64'd2);
    cyc(); req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp full ready", 64'(req_ready), 64'd0);
      chk("bp hold valid", 64'(rsp_valid), 64'd1);
      chk("bp hold id", 64'(rsp_id), 64'd0);
      chk("bp hold b", rsp_b, ba[0]);
      if (i < 4) cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("bp release accept", 64'(req_ready), 64'd4);
    cyc(); req_valid = '0;
    #1 chk("bp drain1 id", 64'(rsp_id), 64'd1);
    chk("bp drain1 b", rsp_b, ba[1]);
    cyc();
    #1 chk("bp drain2 id", 64'(rsp_id), 64'd2);
    chk("bp drain2 b", rsp_b, ba[2]);
    cyc();
    #1 chk("bp empty", 64'(rsp_valid), 64'd0);
    chk("bp ops_done", 64'(ops_done), 64'd3);
    @(negedge clk);

    // Reset mid-flight with S1 and S2 occupied.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    cyc(); req_valid = 4'b0010;
    cyc(); req_valid = 4'b0100; reset_n = 1'b0;
    #1 chk("midrst ready forced", 64'(req_ready), 64'd0);
    @(negedge clk);
    cyc();
    reset_n = 1'b1; req_valid = '0;
    #1 chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst ops_done", 64'(ops_done), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1 chk("midrst no stale", 64'(rsp_valid), 64'd0);
    end
    req_valid = 4'hF;
    #1 chk("midrst ptr zero", 64'(req_ready), 64'd1);
    req_valid = '0;
    @(negedge clk);

    // Counter wrap: steady one response per cycle, ops_done = edges - 2.
    do_reset();
    req_valid = 4'hF;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    chk("wrap ffff", 64'(ops_done), 64'hFFFF);
    cyc();
    chk("wrap zero", 64'(ops_done), 64'd0);
    req_valid = '0; cyc(); cyc();

    // Random soak against a bit-serial rotate model.
    do_reset();
    pend = '0; scnt = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < Ports; p++) begin
        if (pend[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
          set_port(p, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
          req_valid[p] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("soak ready legal",
          64'(((req_ready & ~req_valid) == 4'b0) && $onehot0(req_ready)), 64'd1);
      for (int p = 0; p < Ports; p++) begin
        pend[p] = req_valid[p] && req_ready[p];
        if (pend[p])
          q.push_back('{IW'(p), rot_ref(req_a[p*Bits +: Bits], int'(req_sh[p*SW +: SW]), req_left[p])});
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("soak unexpected rsp", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("soak id", 64'(rsp_id), 64'(e.id));
          chk("soak b", rsp_b, e.b);
        end
        scnt++;
      end
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid) begin
        if (q.size() == 0) chk("drain unexpected rsp", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("drain id", 64'(rsp_id), 64'(e.id));
          chk("drain b", rsp_b, e.b);
        end
        scnt++;
      end
      @(negedge clk);
    end
    chk("soak queue empty", 64'(q.size()), 64'd0);
    chk("soak ops_done", 64'(ops_done), 64'(scnt % 65536));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
